// File: rtl/dma_addr_buffer.sv
// DMA address buffer: circular address queue feeding a tri-stated system bus.
// In slave mode it decodes the bus into a latched register select.
module dma_addr_buffer #(
    parameter int ADDR_W = 16,
    parameter int SEL_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              AEN,
    input  logic              HLDA,
    input  logic              MemToMem,
    input  logic              conc_flag_out,
    input  logic              TReady,
    input  logic              IReady,
    input  logic [ADDR_W-1:0] address_in,
    input  logic              addr_valid,
    inout  wire  [ADDR_W-1:0] address_bus,
    output logic [SEL_W-1:0]  out_address,
    output logic              address_ready,
    output logic              addr_full,
    output logic              addr_empty,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, MM_WAIT} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  out_reg;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               ireq_prev;
    logic               ireq_rise;
    logic               push, pop;
    logic               bus_known, bus_hi_zero, bus_lower, bus_upper;

    assign address_bus = AEN ? out_reg : 'z;

    assign addr_full  = (count == CW'(DEPTH));
    assign addr_empty = (count == '0);
    assign push       = addr_valid && !addr_full;
    assign ireq_rise  = IReady && !ireq_prev;

    // Register window decode; assumes ADDR_W > SEL_W.
    assign bus_known   = !$isunknown(address_bus);
    assign bus_hi_zero = ~|address_bus[ADDR_W-1:SEL_W];
    assign bus_lower   = bus_known && bus_hi_zero && !address_bus[SEL_W-1];
    assign bus_upper   = bus_known && bus_hi_zero &&  address_bus[SEL_W-1];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!AEN || !HLDA) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!addr_empty) state_nxt = DRIVE;
                DRIVE:   if (MemToMem) state_nxt = MM_WAIT;
                         else if (TReady && addr_empty) state_nxt = IDLE;
                MM_WAIT: if (ireq_rise) state_nxt = addr_empty ? IDLE : DRIVE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        pop           = 1'b0;
        address_ready = (state == MM_WAIT);
        if (AEN && HLDA && !addr_empty) begin
            case (state)
                IDLE:    pop = 1'b1;
                DRIVE:   pop = !MemToMem && TReady;
                MM_WAIT: pop = ireq_rise;
                default: pop = 1'b0;
            endcase
        end
    end

    // NOTE: the queue storage is not reset; the pointers and count define
    // which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= address_in;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_reg   <= '0;
            overflow  <= 1'b0;
            ireq_prev <= 1'b0;
        end else begin
            ireq_prev <= IReady;
            if (addr_valid && addr_full) overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                out_reg <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Lower half of the window honours the byte-pointer freeze; upper half always loads.
    always_ff @(posedge clk) begin
        if (Reset) begin
            out_address <= '0;
        end else if (!AEN) begin
            if (bus_upper || (bus_lower && !conc_flag_out))
                out_address <= address_bus[SEL_W-1:0];
        end
    end

endmodule

// File: tb/tb_dma_addr_buffer.sv
// Self-checking bench for dma_addr_buffer: slave decode vectors plus
// scoreboarded master, full-queue and mem-to-mem sequences.
module tb_dma_addr_buffer;

    logic        clk = 1'b0;
    logic        Reset, AEN, HLDA, MemToMem, conc_flag_out, TReady, IReady;
    logic [15:0] address_in;
    logic        addr_valid;
    wire  [15:0] address_bus;
    logic [3:0]  out_address;
    logic        address_ready, addr_full, addr_empty, overflow;
    logic [15:0] bus_drv;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] sb [$];
    logic        exp_ovf;

    typedef struct {
        logic        conc;
        logic [15:0] bus;
        logic [3:0]  exp;
    } slave_vec_t;

    slave_vec_t vecs [10];

    assign address_bus = AEN ? 'z : bus_drv;

    always #5 clk = ~clk;

    dma_addr_buffer #(.ADDR_W(16), .SEL_W(4), .DEPTH(4)) dut (
        .clk(clk), .Reset(Reset), .AEN(AEN), .HLDA(HLDA), .MemToMem(MemToMem),
        .conc_flag_out(conc_flag_out), .TReady(TReady), .IReady(IReady),
        .address_in(address_in), .addr_valid(addr_valid), .address_bus(address_bus),
        .out_address(out_address), .address_ready(address_ready),
        .addr_full(addr_full), .addr_empty(addr_empty), .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives a push and records its fate in the model (push decided on pre-pop count).
    task automatic model_push(input logic [15:0] a);
        address_in = a;
        addr_valid = 1'b1;
        if (sb.size() < 4) sb.push_back(a);
        else exp_ovf = 1'b1;
    endtask

    task automatic expect_pop(input string name);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got bus %h but scoreboard has no entry", name, address_bus);
        end else begin
            check(name, {16'h0, address_bus}, {16'h0, sb.pop_front()});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 16'h0005, 4'h5};
        vecs[1] = '{1'b1, 16'h0003, 4'h5};
        vecs[2] = '{1'b0, 16'h000A, 4'hA};
        vecs[3] = '{1'b0, 16'h1234, 4'hA};
        vecs[4] = '{1'b1, 16'h000C, 4'hC};
        vecs[5] = '{1'b0, 16'h0010, 4'hC};
        vecs[6] = '{1'b0, 16'h0007, 4'h7};
        vecs[7] = '{1'b1, 16'h0000, 4'h7};
        vecs[8] = '{1'b0, 16'h0008, 4'h8};
        vecs[9] = '{1'b0, 16'hFFFF, 4'h8};

        Reset = 1'b1; AEN = 1'b1; HLDA = 1'b0; MemToMem = 1'b0; conc_flag_out = 1'b0;
        TReady = 1'b0; IReady = 1'b0; addr_valid = 1'b0; address_in = '0; bus_drv = '0;
        exp_ovf = 1'b0;
        tick();
        tick();
        check("rst_out_address", out_address, 0);
        check("rst_ready", address_ready, 0);
        check("rst_empty_full", {addr_empty, addr_full}, 2'b10);
        check("rst_overflow", overflow, 0);
        check("rst_bus", address_bus, 0);
        Reset = 1'b0;

        // Slave-mode register select decode
        AEN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            conc_flag_out = vecs[i].conc;
            bus_drv       = vecs[i].bus;
            tick();
            check($sformatf("slave_vec%0d", i), out_address, vecs[i].exp);
        end
        conc_flag_out = 1'b0;

        // Master mode, TReady pulsed
        AEN = 1'b1;
        model_push(16'h1000); tick();
        model_push(16'h1001); tick();
        model_push(16'h1002); tick();
        addr_valid = 1'b0;
        check("m_not_empty", addr_empty, 0);
        HLDA = 1'b1;
        tick(); expect_pop("m_pop0");
        TReady = 1'b1; tick(); expect_pop("m_pop1");
        TReady = 1'b0; tick(); check("m_hold", address_bus, 16'h1001);
        TReady = 1'b1; tick(); expect_pop("m_pop2");
        check("m_empty", addr_empty, 1);
        tick();
        check("m_idle_bus", address_bus, 16'h1002);
        check("m_idle_ready", address_ready, 0);
        TReady = 1'b0;
        model_push(16'h1003); tick();
        check("m_no_pop_empty", address_bus, 16'h1002);
        addr_valid = 1'b0;
        tick(); expect_pop("m_idle_pop");
        HLDA = 1'b0; tick();

        // Full queue and overflow
        Reset = 1'b1; tick(); Reset = 1'b0;
        sb.delete(); exp_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            model_push(16'h3000 + 16'(i));
            tick();
            check($sformatf("full_ovf%0d", i), {addr_full, overflow}, {sb.size() == 4, exp_ovf});
        end
        addr_valid = 1'b0;
        HLDA = 1'b1; TReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_pop($sformatf("full_drain%0d", i));
        end
        tick();
        check("full_fifth_absent", address_bus, 16'h3003);
        check("full_drained_empty", addr_empty, 1);
        HLDA = 1'b0; TReady = 1'b0;
        model_push(16'h4000); tick();
        model_push(16'h4001); tick();
        model_push(16'h4002); tick();
        HLDA = 1'b1;
        model_push(16'h4003); tick();
        expect_pop("pp_pop");
        check("pp_count3_not_full", addr_full, 0);
        model_push(16'h4004); tick();
        check("pp_then_full", addr_full, 1);
        model_push(16'h4005); TReady = 1'b1; tick();
        expect_pop("full_pop_drop");
        addr_valid = 1'b0;
        check("full_pop_drop_count", addr_full, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pop($sformatf("pp_drain%0d", i));
        end
        check("pp_drained_empty", addr_empty, 1);
        tick();
        check("pp_dropped_absent", address_bus, 16'h4004);
        check("ovf_sticky", overflow, exp_ovf);
        TReady = 1'b0; HLDA = 1'b0; tick();

        // Mem-to-mem handshake
        Reset = 1'b1; tick(); Reset = 1'b0;
        sb.delete(); exp_ovf = 1'b0;
        check("mm_ovf_cleared", overflow, 0);
        model_push(16'h2000); tick();
        model_push(16'h2004); tick();
        addr_valid = 1'b0;
        MemToMem = 1'b1; TReady = 1'b1; IReady = 1'b0; HLDA = 1'b1;
        tick(); expect_pop("mm_pop0");
        check("mm_ready_drive", address_ready, 0);
        IReady = 1'b1; tick();
        check("mm_ready_set", {15'h0, address_ready, address_bus}, {15'h0, 1'b1, 16'h2000});
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("mm_held_high%0d", i), {15'h0, address_ready, address_bus}, {15'h0, 1'b1, 16'h2000});
        end
        IReady = 1'b0; tick();
        check("mm_low_wait", address_ready, 1);
        IReady = 1'b1; tick();
        expect_pop("mm_edge_pop");
        check("mm_edge_clear", address_ready, 0);
        tick();
        check("mm_ready_again", address_ready, 1);
        IReady = 1'b0; tick();
        IReady = 1'b1; tick();
        check("mm_empty_idle", {15'h0, address_ready, address_bus}, {15'h0, 1'b0, 16'h2004});

        // HLDA drop in MM_WAIT, then reset mid-DRIVE
        IReady = 1'b0; HLDA = 1'b0; tick();
        model_push(16'h5000); tick();
        model_push(16'h5001); tick();
        model_push(16'h5002); tick();
        addr_valid = 1'b0;
        HLDA = 1'b1; tick(); expect_pop("hd_pop0");
        tick(); check("hd_mm_wait", address_ready, 1);
        HLDA = 1'b0; tick();
        check("hd_drop_ready", address_ready, 0);
        check("hd_queue_kept", addr_empty, 0);
        HLDA = 1'b1; tick(); expect_pop("hd_resume_pop");
        MemToMem = 1'b0; TReady = 1'b0; tick();
        check("hd_drive_hold", address_bus, 16'h5001);
        Reset = 1'b1; tick();
        sb.delete();
        check("rst_mid_empty", {addr_empty, addr_full, address_ready}, 3'b100);
        check("rst_mid_bus", address_bus, 0);
        Reset = 1'b0; tick();
        check("post_rst_bus", {15'h0, addr_empty, address_bus}, {15'h0, 1'b1, 16'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_addr_buffer.md
DMA_ADDR_BUFFER -- requirements
Module: dma_addr_buffer

Interface
REQ-001 Parameter ADDR_W, default 16: address bus and address queue width.
REQ-002 Parameter SEL_W, default 4: register-select width; the DMA register window is 0 .. 2^SEL_W-1.
REQ-003 Parameter DEPTH, default 4: address queue entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 AEN  input  1  address enable; 1 = master (DMA drives the bus), 0 = slave (CPU drives the bus).
REQ-007 HLDA  input  1  hold acknowledge from the CPU.
REQ-008 MemToMem  input  1  memory-to-memory transfer mode.
REQ-009 conc_flag_out  input  1  byte-pointer flip-flop; 1 freezes lower-window register select.
REQ-010 TReady  input  1  target ready; accepts the current bus address.
REQ-011 IReady  input  1  initiator ready; mem-to-mem handshake return.
REQ-012 address_in  input  ADDR_W  address to enqueue.
REQ-013 addr_valid  input  1  push strobe for address_in.
REQ-014 address_bus  inout  ADDR_W  system address bus.
REQ-015 out_address  output  SEL_W  latched register select.
REQ-016 address_ready  output  1  mem-to-mem address presented, awaiting IReady.
REQ-017 addr_full / addr_empty  output  1 each  queue status.
REQ-018 overflow  output  1  sticky: a push was dropped.

Function
REQ-019 address_bus SHALL be driven with out_reg when AEN=1 and SHALL be high-Z otherwise (combinational).
REQ-020 Slave mode (AEN=0), each edge: bus < 2^(SEL_W-1) -> out_address loads bus[SEL_W-1:0] only if conc_flag_out=0, else holds.
REQ-021 Slave mode: 2^(SEL_W-1) <= bus < 2^SEL_W -> out_address always loads; bus >= 2^SEL_W, or any X/Z bit -> out_address holds.
REQ-022 Queue: circular FIFO, DEPTH entries; pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-023 Push on addr_valid=1 and count<DEPTH, evaluated before any same-cycle pop; full push is dropped and sets overflow.
REQ-024 Same-cycle push and pop on a non-full queue SHALL leave count unchanged.
REQ-025 FSM states IDLE, DRIVE, MM_WAIT; pop = load out_reg from head, advance read pointer; 1-cycle latency head -> bus.
REQ-026 IDLE: AEN=1 & HLDA=1 & !empty -> pop, go DRIVE; else stay.
REQ-027 DRIVE, MemToMem=0: TReady=1 -> pop if !empty (stay DRIVE), else go IDLE; TReady=0 -> hold.
REQ-028 DRIVE, MemToMem=1: set address_ready=1, go MM_WAIT; TReady is ignored.
REQ-029 MM_WAIT: an IReady rising edge (IReady=1, previous-cycle IReady=0) clears address_ready and pops if !empty -> DRIVE, else -> IDLE.
REQ-030 IReady held high on entry to MM_WAIT is not an edge; the block waits for a 0->1 transition.
REQ-031 AEN=0 or HLDA=0 in any state -> next state IDLE, address_ready=0, out_reg and queue unchanged, no pop.
REQ-032 Simultaneous TReady and IReady edge: mode selects the relevant one; the other is ignored.

Reset
REQ-033 Reset=1 at an edge: state IDLE, queue empty (pointers 0), out_reg=0, out_address=0, address_ready=0, overflow=0, IReady history=0; it overrides all other inputs.
REQ-034 Reset mid-transfer (DRIVE or MM_WAIT) SHALL discard queued addresses; the bus stays driven with 0 while AEN=1.

Verification
REQ-035 Slave: AEN=0, conc=0, bus=5 -> out_address=5; conc=1, bus=3 -> holds 5; bus=0xA -> 0xA; bus=0x1234 -> holds 0xA.
REQ-036 Master: push 0x1000,0x1001,0x1002, AEN=HLDA=1, TReady pulsed -> bus shows 0x1000, 0x1001, 0x1002 one per pulse, then IDLE with empty=1.
REQ-037 Full: DEPTH=4, push 5 without pop -> full=1, overflow=1, 5th value absent; push and pop in the same cycle when count=3 -> count stays 3.
REQ-038 Mem-to-mem: MemToMem=1, push 0x2000,0x2004 -> address_ready=1 with bus=0x2000; IReady held 1 -> no advance; IReady 0->1 -> bus=0x2004 and address_ready pulses again.
REQ-039 HLDA drops during MM_WAIT -> address_ready=0, IDLE, queue count preserved; Reset mid-DRIVE -> empty=1, bus=0 with AEN=1.
